// File: rtl/trap_ctrl.sv
// trap_ctrl: trap/interrupt sequencer selecting the next PC source at instruction boundaries.
module trap_ctrl #(
  parameter int A = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [A-1:0] pc,
  input  logic         instr_done,
  input  logic         stall,
  input  logic         illegal,
  input  logic         swi,
  input  logic         rti,
  input  logic         irq_ext,
  input  logic         irq_tmr,
  output logic [2:0]   trapSel,
  output logic [A-1:0] epc,
  output logic [1:0]   cause,
  output logic         in_trap,
  output logic         trap_taken,
  output logic         dbl_fault
);
  typedef enum logic [1:0] {RSTV, RUN, VEC} state_t;
  state_t state, state_d;
  logic tmr_pend, acc, flt, dbl, irq_take;
  logic [2:0] sel_d;
  logic [A-1:0] epc_d;
  logic [1:0] cause_d;
  logic trap_d, taken_d, tmr_d;
  assign acc = instr_done & ~stall & (state == RUN);
  assign flt = acc & (illegal | swi);
  assign dbl = flt & in_trap;
  assign irq_take = acc & ~(illegal | swi) & (irq_ext | tmr_pend) & ~in_trap;
  always_ff @(posedge clk) begin
    if (!rst_n) state <= RSTV;
    else state <= state_d;
  end
  // a double fault reuses RSTV so the 0x0000 vector lasts one cycle and boundaries are ignored
  always_comb begin
    state_d = (state == RSTV) ? RUN : dbl ? RSTV : (flt | irq_take) ? VEC : RUN;
  end
  always_comb begin
    sel_d   = dbl ? 3'b100 : flt ? (illegal ? 3'b001 : 3'b010) : irq_take ? 3'b011 : acc ? 3'b111 : 3'b000;
    taken_d = (flt & ~in_trap) | irq_take;
    trap_d  = taken_d ? 1'b1 : (dbl | (acc & rti)) ? 1'b0 : in_trap;
    epc_d   = (dbl | (flt & illegal)) ? pc : taken_d ? pc + A'(2) : epc;
    cause_d = flt ? (illegal ? 2'd1 : 2'd2) : irq_take ? 2'd3 : cause;
    tmr_d   = irq_tmr | (tmr_pend & ~(irq_take & ~irq_ext));
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      trapSel    <= 3'b100;
      epc        <= '0;
      cause      <= '0;
      in_trap    <= 1'b0;
      trap_taken <= 1'b0;
      dbl_fault  <= 1'b0;
      tmr_pend   <= 1'b0;
    end else begin
      trapSel    <= sel_d;
      epc        <= epc_d;
      cause      <= cause_d;
      in_trap    <= trap_d;
      trap_taken <= taken_d;
      dbl_fault  <= dbl_fault | dbl;
      tmr_pend   <= tmr_d;
    end
  end
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: table-driven directed checks for trap_ctrl plus hand-written corner sequences.
module tb_trap_ctrl;
  logic clk = 0, rst_n = 0, instr_done = 0, stall = 0, illegal = 0, swi = 0, rti = 0, irq_ext = 0, irq_tmr = 0;
  logic [15:0] pc = 0;
  logic [2:0] trapSel;
  logic [15:0] epc;
  logic [1:0] cause;
  logic in_trap, trap_taken, dbl_fault;
  int checks = 0, failures = 0;

  trap_ctrl #(.A(16)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .instr_done(instr_done), .stall(stall),
    .illegal(illegal), .swi(swi), .rti(rti), .irq_ext(irq_ext), .irq_tmr(irq_tmr),
    .trapSel(trapSel), .epc(epc), .cause(cause), .in_trap(in_trap),
    .trap_taken(trap_taken), .dbl_fault(dbl_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic r; logic [15:0] p; logic d, s, il, sw, rt, ex, tm;
    logic [2:0] sel; logic [15:0] e; logic [1:0] c; logic tr, tk, db;
  } vec_t;

  function automatic vec_t mk(logic r, logic [15:0] p, logic d, s, il, sw, rt, ex, tm,
                              logic [2:0] sel, logic [15:0] e, logic [1:0] c, logic tr, tk, db);
    vec_t v;
    v.r = r; v.p = p; v.d = d; v.s = s; v.il = il; v.sw = sw; v.rt = rt; v.ex = ex; v.tm = tm;
    v.sel = sel; v.e = e; v.c = c; v.tr = tr; v.tk = tk; v.db = db;
    return v;
  endfunction

  task automatic cmp(string name, int idx, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic step(vec_t v, int idx);
    rst_n = v.r; pc = v.p; instr_done = v.d; stall = v.s; illegal = v.il; swi = v.sw;
    rti = v.rt; irq_ext = v.ex; irq_tmr = v.tm;
    @(negedge clk);
    cmp("trapSel", idx, {13'd0, trapSel}, {13'd0, v.sel});
    cmp("epc", idx, epc, v.e);
    cmp("cause", idx, {14'd0, cause}, {14'd0, v.c});
    cmp("in_trap", idx, {15'd0, in_trap}, {15'd0, v.tr});
    cmp("trap_taken", idx, {15'd0, trap_taken}, {15'd0, v.tk});
    cmp("dbl_fault", idx, {15'd0, dbl_fault}, {15'd0, v.db});
  endtask

  vec_t tbl[30];

  initial begin
    //                r  pc       d s il sw rt ex tm  sel     epc      c  tr tk db
    tbl[0]  = mk(0, 16'h0000, 0,0,0,0,0,0,0, 3'b100, 16'h0000, 0, 0,0,0);
    tbl[1]  = mk(0, 16'h0000, 0,0,0,0,0,0,0, 3'b100, 16'h0000, 0, 0,0,0);
    tbl[2]  = mk(0, 16'h0000, 0,0,0,0,0,0,0, 3'b100, 16'h0000, 0, 0,0,0);
    tbl[3]  = mk(1, 16'h0000, 0,0,0,0,0,0,0, 3'b000, 16'h0000, 0, 0,0,0);
    tbl[4]  = mk(1, 16'h1234, 1,0,0,0,0,0,0, 3'b111, 16'h0000, 0, 0,0,0);
    tbl[5]  = mk(1, 16'h1234, 0,0,0,0,0,0,0, 3'b000, 16'h0000, 0, 0,0,0);
    tbl[6]  = mk(1, 16'h0100, 1,1,1,0,0,0,0, 3'b000, 16'h0000, 0, 0,0,0);
    tbl[7]  = mk(1, 16'h0200, 1,0,1,1,0,1,0, 3'b001, 16'h0200, 1, 1,1,0);
    tbl[8]  = mk(1, 16'h0400, 0,0,0,0,0,0,0, 3'b000, 16'h0200, 1, 1,0,0);
    tbl[9]  = mk(1, 16'h0400, 0,0,0,0,0,0,1, 3'b000, 16'h0200, 1, 1,0,0);
    tbl[10] = mk(1, 16'h0C00, 1,0,0,0,0,0,0, 3'b111, 16'h0200, 1, 1,0,0);
    tbl[11] = mk(1, 16'h0C02, 0,0,0,0,0,0,0, 3'b000, 16'h0200, 1, 1,0,0);
    tbl[12] = mk(1, 16'h0C02, 1,0,0,0,0,0,0, 3'b111, 16'h0200, 1, 1,0,0);
    tbl[13] = mk(1, 16'h0C10, 1,0,0,0,1,0,0, 3'b111, 16'h0200, 1, 0,0,0);
    tbl[14] = mk(1, 16'h0C12, 1,0,0,0,0,0,0, 3'b011, 16'h0C14, 3, 1,1,0);
    tbl[15] = mk(1, 16'h0C00, 0,0,0,0,0,0,0, 3'b000, 16'h0C14, 3, 1,0,0);
    tbl[16] = mk(1, 16'h0C20, 1,0,0,0,1,0,0, 3'b111, 16'h0C14, 3, 0,0,0);
    tbl[17] = mk(1, 16'h0C22, 1,0,0,0,0,0,0, 3'b111, 16'h0C14, 3, 0,0,0);
    tbl[18] = mk(1, 16'h0C24, 0,0,0,0,0,0,0, 3'b000, 16'h0C14, 3, 0,0,0);
    tbl[19] = mk(1, 16'hFFFE, 1,0,0,1,0,0,0, 3'b010, 16'h0000, 2, 1,1,0);
    tbl[20] = mk(1, 16'h0800, 0,0,0,0,0,0,0, 3'b000, 16'h0000, 2, 1,0,0);
    tbl[21] = mk(1, 16'h0040, 1,0,1,0,0,0,0, 3'b100, 16'h0040, 1, 0,0,1);
    tbl[22] = mk(1, 16'h0000, 0,0,0,0,0,0,0, 3'b000, 16'h0040, 1, 0,0,1);
    tbl[23] = mk(1, 16'h0050, 1,0,0,0,0,1,0, 3'b011, 16'h0052, 3, 1,1,1);
    tbl[24] = mk(1, 16'h0C00, 0,0,0,0,0,1,0, 3'b000, 16'h0052, 3, 1,0,1);
    tbl[25] = mk(1, 16'h0060, 1,0,0,0,1,0,0, 3'b111, 16'h0052, 3, 0,0,1);
    tbl[26] = mk(1, 16'h0070, 1,0,0,0,0,0,1, 3'b111, 16'h0052, 3, 0,0,1);
    tbl[27] = mk(0, 16'h0072, 0,0,0,0,0,0,0, 3'b100, 16'h0000, 0, 0,0,0);
    tbl[28] = mk(1, 16'h0000, 0,0,0,0,0,0,0, 3'b000, 16'h0000, 0, 0,0,0);
    tbl[29] = mk(1, 16'h0080, 1,0,0,0,0,0,0, 3'b111, 16'h0000, 0, 0,0,0);
    @(negedge clk);
    for (int i = 0; i < 30; i++) step(tbl[i], i);
    // boundary during VEC is ignored, then reset lands while in VEC with an irq just taken
    step(mk(1, 16'h0300, 1,0,1,0,0,0,0, 3'b001, 16'h0300, 1, 1,1,0), 100);
    step(mk(1, 16'h0302, 1,0,0,1,0,0,0, 3'b000, 16'h0300, 1, 1,0,0), 101);
    step(mk(1, 16'h0310, 1,0,0,0,1,0,0, 3'b111, 16'h0300, 1, 0,0,0), 102);
    step(mk(1, 16'h0320, 1,0,0,0,0,1,1, 3'b011, 16'h0322, 3, 1,1,0), 103);
    step(mk(0, 16'h0C00, 0,0,0,0,0,0,0, 3'b100, 16'h0000, 0, 0,0,0), 104);
    step(mk(1, 16'h0000, 0,0,0,0,0,0,0, 3'b000, 16'h0000, 0, 0,0,0), 105);
    step(mk(1, 16'h0330, 1,0,0,0,0,0,0, 3'b111, 16'h0000, 0, 0,0,0), 106);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
